// File: rtl/serial_subtractor_if.sv
// Start/done handshake and operand/result bus of the bit-serial subtractor.
// The master issues operations; the slave (the subtractor) returns results.
interface serial_subtractor_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] D;
    logic             b;

    modport master (
        output start, A, B,
        input  busy, done, D, b
    );

    modport slave (
        input  start, A, B,
        output busy, done, D, b
    );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial A - B, LSB first, one bit per clock through a full-subtractor
// built from two chained half-subtractors. Result and final borrow are held until the next completion.
module serial_subtractor #(
    parameter int unsigned WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    serial_subtractor_if.slave bus
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;
    logic             r_bin;
    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_d_out;
    logic             r_b_out;

    logic             w_a0;
    logic             w_b0;
    logic             w_hs1_d;
    logic             w_hs1_bo;
    logic             w_diff;
    logic             w_hs2_bo;
    logic             w_bout;
    logic [WIDTH-1:0] w_res_next;

    // Full subtractor: first half-subtractor on a0/b0, second folds in the borrow-in.
    assign w_a0       = r_a[0];
    assign w_b0       = r_b[0];
    assign w_hs1_d    = w_a0 ^ w_b0;
    assign w_hs1_bo   = ~w_a0 & w_b0;
    assign w_diff     = w_hs1_d ^ r_bin;
    assign w_hs2_bo   = ~w_hs1_d & r_bin;
    assign w_bout     = w_hs1_bo | w_hs2_bo;
    assign w_res_next = {w_diff, r_res[WIDTH-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_bin   <= 1'b0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_d_out <= '0;
            r_b_out <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    r_done <= 1'b0;
                    if (bus.start) begin
                        r_a     <= bus.A;
                        r_b     <= bus.B;
                        r_bin   <= 1'b0;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_SHIFT;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_SHIFT: begin
                    r_res <= w_res_next;
                    r_a   <= r_a >> 1;
                    r_b   <= r_b >> 1;
                    r_bin <= w_bout;
                    r_cnt <= r_cnt + CNT_W'(1);
                    // Last bit: publish the completed word and final borrow.
                    if (r_cnt == LAST_BIT) begin
                        r_d_out <= w_res_next;
                        r_b_out <= w_bout;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_DONE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.D    = r_d_out;
    assign bus.b    = r_b_out;

endmodule
